// File: rtl/dna_pattern_search.sv
// Sliding-window DNA pattern searcher over two 1-cycle-latency ROMs.
// Loads up to MAX_PAT pattern symbols, then streams DNA one symbol per cycle.
// Ports: clock, reset_N (sync, active low), ready/count_mode start request,
//   dna_start/dna_length/pattern_start/pattern_len request fields,
//   dna_re/dna_addr/dna_data and pat_re/pat_addr/pat_data ROM interfaces,
//   done/found_it/error/found_location/match_count results.
// Optional: define DNA_SEARCH_WILDCARD_EN to add a pat_wild input whose
//   per-slot mask makes a pattern slot match any DNA symbol.
module dna_pattern_search #(
    parameter int ADDR_W  = 16,
    parameter int PADDR_W = 12,
    parameter int SYM_W   = 2,
    parameter int MAX_PAT = 8,
    parameter int COUNT_W = 8
) (
    input  logic                         clock,
    input  logic                         reset_N,
    input  logic                         ready,
    input  logic                         count_mode,
    input  logic [ADDR_W-1:0]            dna_start,
    input  logic [ADDR_W-1:0]            dna_length,
    input  logic [PADDR_W-1:0]           pattern_start,
    input  logic [$clog2(MAX_PAT+1)-1:0] pattern_len,
    output logic                         dna_re,
    output logic [ADDR_W-1:0]            dna_addr,
    input  logic [SYM_W-1:0]             dna_data,
    output logic                         pat_re,
    output logic [PADDR_W-1:0]           pat_addr,
    input  logic [SYM_W-1:0]             pat_data,
`ifdef DNA_SEARCH_WILDCARD_EN
    input  logic                         pat_wild,
`endif
    output logic                         done,
    output logic                         found_it,
    output logic                         error,
    output logic [ADDR_W-1:0]            found_location,
    output logic [COUNT_W-1:0]           match_count
);

    localparam int PLW = $clog2(MAX_PAT + 1);
    localparam int CW  = ADDR_W + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;

    logic [CW-1:0]      cnt;
    logic [ADDR_W-1:0]  dna_start_q;
    logic [ADDR_W-1:0]  dna_len_q;
    logic [PADDR_W-1:0] pat_start_q;
    logic [PLW-1:0]     len_q;
    logic               mode_q;

    // Both buffers are shift registers with the newest symbol at index 0,
    // so window entry w always lines up with pattern entry w.
    logic [MAX_PAT-1:0][SYM_W-1:0] win;
    logic [MAX_PAT-1:0][SYM_W-1:0] pbuf;
    logic [MAX_PAT-1:0][SYM_W-1:0] win_next;
`ifdef DNA_SEARCH_WILDCARD_EN
    logic [MAX_PAT-1:0]            wbuf;
`endif

    logic [CW-1:0]     len_c;
    logic [CW-1:0]     dlen_c;
    logic              hit;
    logic              match;
    logic [ADDR_W-1:0] loc;

    assign len_c    = CW'(len_q);
    assign dlen_c   = CW'(dna_len_q);
    assign win_next = {win[MAX_PAT-2:0], dna_data};

    always_comb begin
        hit = 1'b1;
        for (int w = 0; w < MAX_PAT; w++) begin
            if (w < int'(len_q)) begin
`ifdef DNA_SEARCH_WILDCARD_EN
                if (!wbuf[w] && (win_next[w] != pbuf[w])) hit = 1'b0;
`else
                if (win_next[w] != pbuf[w]) hit = 1'b0;
`endif
            end
        end
    end

    // cnt is the number of symbols received once this cycle's data lands.
    assign match = (state == S_SCAN) && (cnt >= len_c) && hit;
    assign loc   = dna_start_q + cnt[ADDR_W-1:0] - ADDR_W'(len_q);

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            state          <= S_IDLE;
            cnt            <= '0;
            dna_start_q    <= '0;
            dna_len_q      <= '0;
            pat_start_q    <= '0;
            len_q          <= '0;
            mode_q         <= 1'b0;
            win            <= '0;
            pbuf           <= '0;
`ifdef DNA_SEARCH_WILDCARD_EN
            wbuf           <= '0;
`endif
            dna_re         <= 1'b0;
            dna_addr       <= '0;
            pat_re         <= 1'b0;
            pat_addr       <= '0;
            done           <= 1'b0;
            found_it       <= 1'b0;
            error          <= 1'b0;
            found_location <= '0;
            match_count    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ready) begin
                        dna_start_q    <= dna_start;
                        dna_len_q      <= dna_length;
                        pat_start_q    <= pattern_start;
                        len_q          <= pattern_len;
                        mode_q         <= count_mode;
                        win            <= '0;
                        done           <= 1'b0;
                        found_it       <= 1'b0;
                        error          <= 1'b0;
                        found_location <= '0;
                        match_count    <= '0;
                        state          <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((len_q == '0) || (int'(len_q) > MAX_PAT) ||
                        (ADDR_W'(len_q) > dna_len_q)) begin
                        error <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pat_re   <= 1'b1;
                        pat_addr <= pat_start_q;
                        cnt      <= '0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt <= cnt + ONE;
                    if (cnt + ONE < len_c) pat_addr <= pat_addr + 1'b1;
                    else                   pat_re   <= 1'b0;
                    if (cnt != '0) begin
                        pbuf <= {pbuf[MAX_PAT-2:0], pat_data};
`ifdef DNA_SEARCH_WILDCARD_EN
                        wbuf <= {wbuf[MAX_PAT-2:0], pat_wild};
`endif
                    end
                    if (cnt == len_c) begin
                        dna_re   <= 1'b1;
                        dna_addr <= dna_start_q;
                        cnt      <= '0;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    cnt <= cnt + ONE;
                    if (cnt + ONE < dlen_c) dna_addr <= dna_addr + 1'b1;
                    else                    dna_re   <= 1'b0;
                    if (cnt != '0) win <= win_next;
                    if (cnt == dlen_c) state <= S_DONE;
                    if (match) begin
                        if (!found_it) begin
                            found_it       <= 1'b1;
                            found_location <= loc;
                        end
                        if (!mode_q) begin
                            match_count <= COUNT_W'(1);
                            dna_re      <= 1'b0;
                            state       <= S_DONE;
                        end else if (match_count != '1) begin
                            match_count <= match_count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    if (!ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dna_pattern_search.sv
// Directed bench for dna_pattern_search with behavioural 1-cycle ROMs.
// Ports: drives request fields, models both ROMs, checks results/latency.
module tb_dna_pattern_search;

    logic        clock;
    logic        reset_N;
    logic        ready;
    logic        count_mode;
    logic [15:0] dna_start;
    logic [15:0] dna_length;
    logic [11:0] pattern_start;
    logic [3:0]  pattern_len;
    logic        dna_re;
    logic [15:0] dna_addr;
    logic [1:0]  dna_data;
    logic        pat_re;
    logic [11:0] pat_addr;
    logic [1:0]  pat_data;
`ifdef DNA_SEARCH_WILDCARD_EN
    logic        pat_wild;
`endif
    logic        done;
    logic        found_it;
    logic        error;
    logic [15:0] found_location;
    logic [7:0]  match_count;

    logic [1:0] dna_mem [0:65535];
    logic [1:0] pat_mem [0:4095];

    int dna_rd_tot;
    int pat_rd_tot;
    int zero_rd_tot;
    int both_tot;
    int passed;
    int total;

    dna_pattern_search dut (
        .clock         (clock),
        .reset_N       (reset_N),
        .ready         (ready),
        .count_mode    (count_mode),
        .dna_start     (dna_start),
        .dna_length    (dna_length),
        .pattern_start (pattern_start),
        .pattern_len   (pattern_len),
        .dna_re        (dna_re),
        .dna_addr      (dna_addr),
        .dna_data      (dna_data),
        .pat_re        (pat_re),
        .pat_addr      (pat_addr),
        .pat_data      (pat_data),
`ifdef DNA_SEARCH_WILDCARD_EN
        .pat_wild      (pat_wild),
`endif
        .done          (done),
        .found_it      (found_it),
        .error         (error),
        .found_location(found_location),
        .match_count   (match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        dna_data    = 2'd0;
        pat_data    = 2'd0;
`ifdef DNA_SEARCH_WILDCARD_EN
        pat_wild    = 1'b0;
`endif
        dna_rd_tot  = 0;
        pat_rd_tot  = 0;
        zero_rd_tot = 0;
        both_tot    = 0;
    end

    always @(posedge clock) begin
        if (dna_re) begin
            dna_data   <= dna_mem[dna_addr];
            dna_rd_tot <= dna_rd_tot + 1;
            if (dna_addr == 16'h0000) zero_rd_tot <= zero_rd_tot + 1;
        end
        if (pat_re) begin
            pat_data   <= pat_mem[pat_addr];
            pat_rd_tot <= pat_rd_tot + 1;
        end
        if (dna_re && pat_re) both_tot <= both_tot + 1;
    end

    task automatic do_search(input logic [15:0] ds, input logic [15:0] dl,
                             input logic [11:0] ps, input logic [3:0] pl,
                             input logic cm, output int lat,
                             output int dr, output int pr);
        int d0;
        int p0;
        @(negedge clock);
        dna_start     = ds;
        dna_length    = dl;
        pattern_start = ps;
        pattern_len   = pl;
        count_mode    = cm;
        ready         = 1'b1;
        d0 = dna_rd_tot;
        p0 = pat_rd_tot;
        @(posedge clock);
        #1;
        ready = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 300) begin
            @(posedge clock);
            #1;
            lat++;
        end
        dr = dna_rd_tot - d0;
        pr = pat_rd_tot - p0;
    endtask

    task automatic test_reset;
        reset_N = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({done, found_it, error, dna_re, pat_re} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000",
                     {done, found_it, error, dna_re, pat_re});
        else passed++;
        total++;
        if (found_location !== 16'h0000)
            $display("FAIL reset_loc got %h want 0000", found_location);
        else passed++;
        total++;
        if (match_count !== 8'd0)
            $display("FAIL reset_count got %0d want 0", match_count);
        else passed++;
        @(negedge clock);
        reset_N = 1'b1;
    endtask

    task automatic test_first_match;
        int lat, dr, pr;
        do_search(16'h0100, 16'd8, 12'h010, 4'd2, 1'b0, lat, dr, pr);
        total++;
        if (done !== 1'b1) $display("FAIL fm_done got %b want 1", done);
        else passed++;
        total++;
        if (lat !== 9) $display("FAIL fm_latency got %0d want 9", lat);
        else passed++;
        total++;
        if (found_it !== 1'b1 || error !== 1'b0)
            $display("FAIL fm_flags got found=%b err=%b want 1 0",
                     found_it, error);
        else passed++;
        total++;
        if (found_location !== 16'h0101)
            $display("FAIL fm_loc got %h want 0101", found_location);
        else passed++;
        total++;
        if (match_count !== 8'd1)
            $display("FAIL fm_count got %0d want 1", match_count);
        else passed++;
        total++;
        if (pr !== 2 || dr !== 4)
            $display("FAIL fm_reads got pat=%0d dna=%0d want 2 4", pr, dr);
        else passed++;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (done !== 1'b1 || found_location !== 16'h0101)
            $display("FAIL fm_hold got done=%b loc=%h want 1 0101",
                     done, found_location);
        else passed++;
    endtask

    task automatic test_count_all;
        int lat, dr, pr;
        do_search(16'h0100, 16'd8, 12'h010, 4'd2, 1'b1, lat, dr, pr);
        total++;
        if (lat !== 14) $display("FAIL ca_latency got %0d want 14", lat);
        else passed++;
        total++;
        if (found_it !== 1'b1 || found_location !== 16'h0101)
            $display("FAIL ca_first got found=%b loc=%h want 1 0101",
                     found_it, found_location);
        else passed++;
        total++;
        if (match_count !== 8'd2)
            $display("FAIL ca_count got %0d want 2", match_count);
        else passed++;
        total++;
        if (dr !== 8) $display("FAIL ca_dna_reads got %0d want 8", dr);
        else passed++;
    endtask

    task automatic test_no_match;
        int lat, dr, pr;
        do_search(16'h0100, 16'd8, 12'h030, 4'd2, 1'b0, lat, dr, pr);
        total++;
        if (lat !== 14) $display("FAIL nm_latency got %0d want 14", lat);
        else passed++;
        total++;
        if ({found_it, error} !== 2'b00 || match_count !== 8'd0)
            $display("FAIL nm_result got found=%b err=%b cnt=%0d want 0 0 0",
                     found_it, error, match_count);
        else passed++;
    endtask

    task automatic test_errors;
        logic [3:0]  pls [3];
        logic [15:0] dls [3];
        int lat, dr, pr;
        pls = '{4'd0, 4'd9, 4'd5};
        dls = '{16'd8, 16'd8, 16'd4};
        for (int i = 0; i < 3; i++) begin
            do_search(16'h0100, dls[i], 12'h010, pls[i], 1'b1, lat, dr, pr);
            total++;
            if (error !== 1'b1 || found_it !== 1'b0 || match_count !== 8'd0)
                $display("FAIL err%0d_flags got err=%b found=%b cnt=%0d want 1 0 0",
                         i, error, found_it, match_count);
            else passed++;
            total++;
            if (lat !== 2) $display("FAIL err%0d_latency got %0d want 2", i, lat);
            else passed++;
            total++;
            if (dr !== 0 || pr !== 0)
                $display("FAIL err%0d_reads got dna=%0d pat=%0d want 0 0",
                         i, dr, pr);
            else passed++;
        end
    endtask

    task automatic test_wrap;
        int lat, dr, pr;
        int z0;
        z0 = zero_rd_tot;
        do_search(16'hFFFE, 16'd4, 12'h020, 4'd2, 1'b0, lat, dr, pr);
        total++;
        if (found_it !== 1'b1 || found_location !== 16'hFFFF)
            $display("FAIL wrap_loc got found=%b loc=%h want 1 ffff",
                     found_it, found_location);
        else passed++;
        total++;
        if (zero_rd_tot - z0 !== 1)
            $display("FAIL wrap_addr got %0d reads at 0000 want 1",
                     zero_rd_tot - z0);
        else passed++;
    endtask

    task automatic test_reset_mid_scan;
        int d0;
        @(negedge clock);
        dna_start     = 16'h0100;
        dna_length    = 16'd8;
        pattern_start = 12'h010;
        pattern_len   = 4'd2;
        count_mode    = 1'b1;
        ready         = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        total++;
        if (dna_re !== 1'b1) $display("FAIL mid_in_scan got dna_re=%b want 1", dna_re);
        else passed++;
        @(negedge clock);
        reset_N = 1'b0;
        @(posedge clock);
        #1;
        d0 = dna_rd_tot;
        total++;
        if ({done, found_it, error, dna_re, pat_re} !== 5'b0 ||
            found_location !== 16'h0 || match_count !== 8'd0)
            $display("FAIL mid_reset got flags=%b loc=%h cnt=%0d want 0",
                     {done, found_it, error, dna_re, pat_re},
                     found_location, match_count);
        else passed++;
        @(negedge clock);
        reset_N = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        total++;
        if (dna_rd_tot - d0 !== 0 || done !== 1'b0)
            $display("FAIL mid_idle got reads=%0d done=%b want 0 0",
                     dna_rd_tot - d0, done);
        else passed++;
        test_first_match();
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset_N       = 1'b0;
        ready         = 1'b0;
        count_mode    = 1'b0;
        dna_start     = '0;
        dna_length    = '0;
        pattern_start = '0;
        pattern_len   = '0;
        for (int i = 0; i < 65536; i++) dna_mem[i] = 2'd0;
        for (int i = 0; i < 4096; i++) pat_mem[i] = 2'd0;
        for (int i = 0; i < 8; i++) dna_mem[16'h0100 + i] = 2'(i % 4);
        pat_mem[12'h010] = 2'd1;
        pat_mem[12'h011] = 2'd2;
        pat_mem[12'h030] = 2'd3;
        pat_mem[12'h031] = 2'd3;
        pat_mem[12'h020] = 2'd2;
        pat_mem[12'h021] = 2'd1;
        dna_mem[16'hFFFE] = 2'd0;
        dna_mem[16'hFFFF] = 2'd2;
        dna_mem[16'h0000] = 2'd1;
        dna_mem[16'h0001] = 2'd3;
        test_reset();
        test_first_match();
        test_count_all();
        test_no_match();
        test_errors();
        test_wrap();
        test_reset_mid_scan();
        total++;
        if (both_tot !== 0)
            $display("FAIL both_re got %0d cycles want 0", both_tot);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dna_pattern_search.md
Name: dna_pattern_search

Overview:
- Parametrised successor to the single-pattern DNA searcher.
- Loads a pattern of up to MAX_PAT symbols from pattern memory into an internal buffer, then streams the DNA memory one symbol per cycle through a sliding-window comparator.
- Two modes: stop at first match, or count every match, including overlapping ones.
- Sits between the lab controller and two external synchronous-read ROMs with 1-cycle read latency.

Parameters:
- ADDR_W, 16: DNA address, dna_start/dna_length and found_location width.
- PADDR_W, 12: pattern memory address width.
- SYM_W, 2: bits per nucleotide. Encoding A=0, C=1, G=2, T=3.
- MAX_PAT, 8: pattern buffer depth in symbols.
- COUNT_W, 8: match_count width, saturating.

Ports:
- clock  in  1  single clock, rising edge.
- reset_N  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- ready  in  1  start request, sampled in IDLE.
- count_mode  in  1  0 = stop at first match, 1 = count all matches. Sampled with ready.
- dna_start  in  ADDR_W  first DNA address.
- dna_length  in  ADDR_W  number of DNA symbols to scan.
- pattern_start  in  PADDR_W  first pattern address.
- pattern_len  in  $clog2(MAX_PAT+1)  pattern length in symbols.
- dna_re  out  1  DNA memory read enable.
- dna_addr  out  ADDR_W  DNA memory address.
- dna_data  in  SYM_W  DNA read data, valid 1 cycle after dna_re.
- pat_re  out  1  pattern memory read enable.
- pat_addr  out  PADDR_W  pattern memory address.
- pat_data  in  SYM_W  pattern read data, valid 1 cycle after pat_re.
- done  out  1  search finished, outputs valid.
- found_it  out  1  at least one match found.
- error  out  1  illegal request.
- found_location  out  ADDR_W  DNA address of the first symbol of the first match.
- match_count  out  COUNT_W  number of matches found.

Behaviour:
- Reset (reset_N=0 at an edge):
  - State goes to IDLE.
  - done, found_it, error, dna_re and pat_re are 0.
  - found_location, match_count and the internal window/pattern buffers are 0.
  - Reset mid-operation aborts immediately. No further memory reads are issued.
- Start: inputs are latched on the edge where state=IDLE and ready=1. Input changes after that edge are ignored until done.
- IDLE -> CHECK: taken on the start edge. done, found_it, error, found_location and match_count are cleared on that edge.
- CHECK (1 cycle): error if pattern_len==0, pattern_len>MAX_PAT, or pattern_len>dna_length.
  - Error path: -> DONE with error=1, found_it=0, match_count=0, no memory reads.
  - Otherwise -> LOAD_PAT.
- LOAD_PAT (pattern_len+1 cycles):
  - pat_re=1 with pat_addr=pattern_start+i for i=0..pattern_len-1, one per cycle.
  - Each returned symbol is written to pattern buffer slot i.
  - -> SCAN after the last symbol is captured.
- SCAN (up to dna_length+1 cycles):
  - dna_re=1 with dna_addr=dna_start+j for j=0..dna_length-1. Address arithmetic is modulo 2^ADDR_W, so addresses wrap.
  - Each returned symbol shifts into the window. Only the newest pattern_len window entries are compared.
  - A match is valid once received>=pattern_len and all pattern_len symbols are equal.
  - Match location = dna_start + received - pattern_len, modulo 2^ADDR_W.
  - On the first match: found_location latches the location and found_it=1.
  - count_mode=0: -> DONE on the match edge. dna_re drops, outstanding read data is discarded, match_count=1.
  - count_mode=1: match_count increments on every match, saturating at 2^COUNT_W-1. found_location keeps the first match.
  - -> DONE after the last symbol is compared.
- DONE:
  - done=1; found_it, error, found_location and match_count are held.
  - Stays in DONE while ready=1. When ready=0 -> IDLE, and outputs hold until the next start.
- Latency: a no-match or count-mode search raises done exactly pattern_len + dna_length + 4 edges after the start edge. An error raises done 2 edges after the start edge.
- Only one memory read is outstanding per cycle. dna_re and pat_re are never both 1.

Optional Feature:
- Macro: DNA_SEARCH_WILDCARD_EN.
- When defined:
  - Adds input pat_wild (1 bit), valid alongside pat_data and captured into a per-slot wildcard mask during LOAD_PAT.
  - A masked slot matches any DNA symbol.
  - A pattern that is entirely wildcard matches at every legal position.
- When undefined:
  - No pat_wild port and no mask registers.
  - Every slot requires exact equality.

Test Plan:
- DNA 0x0100..0x0107 = 0,1,2,3,0,1,2,3; pattern 0x010 = 1,2; pattern_len=2, dna_length=8, count_mode=0 -> done, found_it=1, found_location=0x0101, match_count=1.
- Same memory image, count_mode=1 -> found_it=1, found_location=0x0101, match_count=2, done exactly 14 edges after start.
- Pattern = 3,3 on the same DNA -> done, found_it=0, match_count=0, error=0.
- pattern_len=0 -> error=1, done 2 edges after start, dna_re and pat_re never asserted. Repeat with pattern_len=9 and with pattern_len=5, dna_length=4 -> error=1.
- dna_start=0xFFFE, dna_length=4, DNA[0xFFFF]=2, DNA[0x0000]=1, pattern 2,1 -> found_location=0xFFFF, dna_addr wraps to 0x0000.
- Assert reset_N=0 for one edge mid-SCAN -> IDLE, all outputs 0, no reads. A following normal search completes correctly.
